// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing, pixel position and blanked, sync-aligned RGB.
// Define VGA_SYNC_BORDER_EN to force an all-ones frame border for monitor alignment.
module vga_sync_gen #(
  parameter int DATA_WIDTH = 3,
  parameter int CLK_DIV = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] iColor,
  output logic [9:0]            widthPos,
  output logic [9:0]            heightPos,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  videoOn,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic                  frameStart
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  typedef enum logic [1:0] {VIS, FP, SYN, BP} phase_t;
  phase_t h_state, h_next, v_state, v_next;
  logic [3:0] div;
  logic tick, h_last, v_last, h_end, v_end, vis;
  logic [DATA_WIDTH-1:0] pix;
  assign tick = div == 4'(CLK_DIV - 1);
  assign h_last = widthPos == 10'(H_TOTAL - 1);
  assign v_last = heightPos == 10'(V_TOTAL - 1);
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      div <= '0;
      widthPos <= '0;
      heightPos <= '0;
      h_state <= VIS;
      v_state <= VIS;
    end else begin
      div <= tick ? '0 : div + 4'd1;
      if (tick) begin
        widthPos <= h_last ? '0 : widthPos + 10'd1;
        if (h_last) heightPos <= v_last ? '0 : heightPos + 10'd1;
        h_state <= h_next;
        v_state <= v_next;
      end
    end
  // Each phase advances on the last position of its period; BP wraps to VIS.
  always_comb begin
    h_end = (h_state == VIS) ? widthPos == 10'(H_VISIBLE - 1) :
            (h_state == FP)  ? widthPos == 10'(H_VISIBLE + H_FRONT - 1) :
            (h_state == SYN) ? widthPos == 10'(H_VISIBLE + H_FRONT + H_SYNC - 1) : h_last;
    v_end = h_last && ((v_state == VIS) ? heightPos == 10'(V_VISIBLE - 1) :
                       (v_state == FP)  ? heightPos == 10'(V_VISIBLE + V_FRONT - 1) :
                       (v_state == SYN) ? heightPos == 10'(V_VISIBLE + V_FRONT + V_SYNC - 1) : v_last);
    h_next = h_end ? phase_t'(h_state + 2'd1) : h_state;
    v_next = v_end ? phase_t'(v_state + 2'd1) : v_state;
  end
  always_comb begin
    vis = h_state == VIS && v_state == VIS;
    pix = vis ? iColor : '0;
`ifdef VGA_SYNC_BORDER_EN
    if (vis && (widthPos == 10'd0 || widthPos == 10'(H_VISIBLE - 1) ||
                heightPos == 10'd0 || heightPos == 10'(V_VISIBLE - 1))) pix = '1;
`endif
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      videoOn <= 1'b0;
      rgb <= '0;
      frameStart <= 1'b0;
    end else begin
      frameStart <= tick && h_last && v_last;
      if (tick) begin
        hsync <= h_state != SYN;
        vsync <= v_state != SYN;
        videoOn <= vis;
        rgb <= pix;
      end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized checks of vga_sync_gen against an arithmetic raster model.
module tb_vga_sync_gen;
  localparam int D = 2;
  localparam int HV = 64, HF = 8, HS = 12, HB = 6;
  localparam int VV = 10, VF = 2, VS = 3, VB = 4;
  localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB, FR = HT * VT;
  localparam logic [26:0] RST_VAL = {20'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
`ifdef VGA_SYNC_BORDER_EN
  localparam logic [2:0] EDGE_RGB = 3'b111;
`else
  localparam logic [2:0] EDGE_RGB = 3'b010;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] icolor, rgb;
  logic [9:0] wpos, hpos;
  logic hsync, vsync, von, fs;
  logic [26:0] obs;
  int unsigned e, xm, ym, ck;
  int vectors = 0, errors = 0;

  vga_sync_gen #(.DATA_WIDTH(3), .CLK_DIV(D),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)) dut (
    .Clock(clk), .Reset(rst), .iColor(icolor), .widthPos(wpos), .heightPos(hpos),
    .hsync(hsync), .vsync(vsync), .videoOn(von), .rgb(rgb), .frameStart(fs));

  always #5 clk = ~clk;
  // Clock edges since reset release; the model derives everything from this.
  always @(posedge clk or posedge rst) if (rst) e <= 0; else e <= e + 1;

  function automatic logic [2:0] color(int unsigned x, int unsigned y, int unsigned a, int unsigned b, int unsigned c);
    int unsigned v;
    v = x * a + y * b + c;
    return v[2:0];
  endfunction

  assign icolor = color(32'(wpos), 32'(hpos), xm, ym, ck);
  assign obs = {wpos, hpos, hsync, vsync, von, rgb, fs};

  function automatic logic [26:0] model(int unsigned edges);
    int unsigned n, x, y, px, py;
    logic hs, vs, vo, f;
    logic [2:0] c;
    n = edges / D;
    x = n % HT;
    y = (n / HT) % VT;
    hs = 1'b1; vs = 1'b1; vo = 1'b0; c = 3'd0;
    if (n > 0) begin
      px = (n - 1) % HT;
      py = ((n - 1) / HT) % VT;
      hs = !(px >= HV + HF && px < HV + HF + HS);
      vs = !(py >= VV + VF && py < VV + VF + VS);
      vo = px < HV && py < VV;
      c = vo ? color(px, py, xm, ym, ck) : 3'd0;
`ifdef VGA_SYNC_BORDER_EN
      if (vo && (px == 0 || px == HV - 1 || py == 0 || py == VV - 1)) c = 3'b111;
`endif
    end
    f = n > 0 && edges % D == 0 && n % FR == 0;
    return {x[9:0], y[9:0], hs, vs, vo, c, f};
  endfunction

  task automatic restart(input int unsigned a, input int unsigned b, input int unsigned c);
    @(negedge clk);
    rst = 1'b1; xm = a; ym = b; ck = c;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) begin
      @(negedge clk);
      vectors++;
      if (obs !== RST_VAL) begin errors++; $display("FAIL reset_hold got %h want %h", obs, RST_VAL); end
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (wpos !== 10'd0) begin errors++; $display("FAIL reset_first_edge widthPos got %0d want 0", wpos); end
    @(negedge clk);
    vectors++;
    if (wpos !== 10'd1) begin errors++; $display("FAIL reset_second_edge widthPos got %0d want 1", wpos); end
  endtask

  task automatic test_line;
    int lows = 0, first = -1, vis = 0, n;
    logic [26:0] exp;
    restart($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    repeat (HT * D) begin
      @(negedge clk);
      exp = model(e);
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL line_cycle e=%0d got %h want %h", e, obs, exp); end
      n = int'(e / D);
      if (e % D == 0 && e > 0) begin
        if (!hsync) begin lows++; if (first < 0) first = n; end
        if (von) vis++;
      end
    end
    vectors += 3;
    if (lows != HS) begin errors++; $display("FAIL hsync_width got %0d want %0d", lows, HS); end
    if (first != HV + HF + 1) begin errors++; $display("FAIL hsync_start got %0d want %0d", first, HV + HF + 1); end
    if (vis != HV) begin errors++; $display("FAIL videoOn_line got %0d want %0d", vis, HV); end
  endtask

  task automatic test_frame;
    int pulses = 0, vlow = 0, vfirst = -1, bad = 0;
    int unsigned t1 = 0, t2 = 0, p;
    logic [26:0] exp;
    restart($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    repeat (2 * FR * D + 4) begin
      @(negedge clk);
      exp = model(e);
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL frame_cycle e=%0d got %h want %h", e, obs, exp); end
      if (fs) begin pulses++; if (pulses == 1) t1 = e; else t2 = e; end
      if (e % D == 0 && e > 0) begin
        p = e / D - 1;
        if (!vsync) begin vlow++; if (vfirst < 0) vfirst = int'(p / HT); end
        if (von && (p / HT) % VT >= VV) bad++;
      end
    end
    vectors += 6;
    if (pulses != 2) begin errors++; $display("FAIL frame_pulses got %0d want 2", pulses); end
    if (t1 != FR * D) begin errors++; $display("FAIL frame_first got %0d want %0d", t1, FR * D); end
    if (t2 - t1 != FR * D) begin errors++; $display("FAIL frame_period got %0d want %0d", t2 - t1, FR * D); end
    if (vlow != 2 * HT * VS) begin errors++; $display("FAIL vsync_width got %0d want %0d", vlow, 2 * HT * VS); end
    if (vfirst != VV + VF) begin errors++; $display("FAIL vsync_start got %0d want %0d", vfirst, VV + VF); end
    if (bad != 0) begin errors++; $display("FAIL videoOn_blank_lines got %0d want 0", bad); end
  endtask

  task automatic test_color;
    logic [26:0] exp;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) restart(1, 0, 0);
      else restart($urandom_range(1, 7), $urandom_range(1, 7), $urandom_range(0, 7));
      repeat ($urandom_range(400, 1500)) begin
        @(negedge clk);
        exp = model(e);
        vectors++;
        if (obs !== exp) begin errors++; $display("FAIL color_cycle pass=%0d e=%0d got %h want %h", pass, e, obs, exp); end
      end
    end
  endtask

  task automatic test_mid_reset;
    int unsigned target, k = 0;
    logic got = 1'b0;
    logic [26:0] exp;
    target = $urandom_range(2 * HT, FR - 1);
    restart($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    while (e < target * D) begin
      @(negedge clk);
      exp = model(e);
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL mid_pre e=%0d got %h want %h", e, obs, exp); end
    end
    #1 rst = 1'b1;
    #1 vectors++;
    if (obs !== RST_VAL) begin errors++; $display("FAIL mid_async got %h want %h", obs, RST_VAL); end
    @(negedge clk);
    rst = 1'b0;
    while (k < FR * D + 8 && !got) begin
      @(negedge clk);
      k++;
      exp = model(e);
      vectors++;
      if (obs !== exp) begin errors++; $display("FAIL mid_post e=%0d got %h want %h", e, obs, exp); end
      if (fs) got = 1'b1;
    end
    vectors++;
    if (!got || k != FR * D) begin errors++; $display("FAIL mid_frame_start got %0d want %0d", k, FR * D); end
  endtask

  task automatic test_border;
    int unsigned p, px, py;
    restart(0, 0, 2);
    repeat (FR * D + 2) begin
      @(negedge clk);
      if (e % D == 0 && e > 0) begin
        p = e / D - 1;
        px = p % HT;
        py = (p / HT) % VT;
        if (px < HV && py < VV) begin
          if (px == 0 || px == HV - 1 || py == 0 || py == VV - 1) begin
            vectors++;
            if (rgb !== EDGE_RGB) begin errors++; $display("FAIL border (%0d,%0d) got %b want %b", px, py, rgb, EDGE_RGB); end
          end else if (px == HV / 2 && py == VV / 2) begin
            vectors++;
            if (rgb !== 3'b010) begin errors++; $display("FAIL border_center got %b want 010", rgb); end
          end
        end
      end
    end
  endtask

  initial begin
    xm = 0; ym = 0; ck = 0;
    test_reset();
    test_line();
    test_frame();
    test_color();
    test_mid_reset();
    test_border();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates VGA 640x480@60 Hz raster timing from the system clock, drives the pixel position (`widthPos`, `heightPos`) consumed by the resolution adapter and video memory, and returns the pixel colour read back from memory as a blanked, sync-aligned RGB output. It is the initiator side of the position/colour interface: it produces pixel coordinates and consumes the colour that comes back.

## Interface
- `DATA_WIDTH`, 3: colour width (1 bit per R/G/B).
- `CLK_DIV`, 2: system clocks per pixel (50 MHz to 25 MHz); legal values 1..15.
- `H_VISIBLE`, 640 / `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal periods in pixels.
- `V_VISIBLE`, 480 / `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: vertical periods in lines.
- `Clock` in 1: system clock; all logic on rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `iColor` in DATA_WIDTH: colour returned by video memory for the current `widthPos`/`heightPos`.
- `widthPos` out 10: horizontal counter, 0..799.
- `heightPos` out 10: vertical counter, 0..524.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `videoOn` out 1: high while the output pixel lies in the visible area.
- `rgb` out DATA_WIDTH: pixel colour to the DAC; zero when blanked.
- `frameStart` out 1: single-`Clock` pulse at the start of each frame.

## Operation
- Divider `div` counts 0..CLK_DIV-1. Pixel tick `tick` = (`div` == CLK_DIV-1). With CLK_DIV=1, `tick` is constantly high.
- On `tick`, `widthPos` increments. At H_TOTAL-1 (799) it wraps to 0 and `heightPos` increments. At V_TOTAL-1 (524) with `widthPos`==799, `heightPos` wraps to 0.
- The horizontal FSM is derived from `widthPos`:
  - H_VIS: 0..639.
  - H_FP: 640..655.
  - H_SYN: 656..751.
  - H_BP: 752..799, then back to H_VIS.
- The vertical FSM uses the same structure on `heightPos`:
  - V_VIS: 0..479.
  - V_FP: 480..489.
  - V_SYN: 490..491.
  - V_BP: 492..524.
- Output stage, registered on `tick`:
  - `hsync` = !(H_SYN).
  - `vsync` = !(V_SYN).
  - `videoOn` = H_VIS && V_VIS.
  - `rgb` = (H_VIS && V_VIS) ? `iColor` : 0.
- All of these are evaluated on the counter values before the increment, so they describe the pixel just addressed.
- Counter widths: 10 bits unsigned. Out-of-range positions are never produced; reaching them is a bug.
- `frameStart` is high for exactly one `Clock` cycle: the cycle after the `tick` edge that loads `widthPos`=0, `heightPos`=0.
- Reset, including mid-frame, forces these values immediately and asynchronously:
  - `div`=0, `widthPos`=0, `heightPos`=0.
  - `hsync`=1, `vsync`=1, `videoOn`=0, `rgb`=0, `frameStart`=0.
- After reset is released, counting restarts from (0,0) and the first frame is full length. No `frameStart` pulse is produced for that first (0,0).

## Timing
- Position to output latency is 1 pixel tick. `rgb`, `hsync`, `vsync` and `videoOn` for pixel (x,y) all update on the same `tick` edge and are mutually aligned.
- Video memory must present `iColor` for the current `widthPos`/`heightPos` within CLK_DIV `Clock` cycles. A one-cycle synchronous RAM satisfies this for CLK_DIV>=2; CLK_DIV=1 requires a combinational read.
- Line period is 800 ticks. Frame period is 420000 ticks, which is 840000 `Clock` cycles at CLK_DIV=2.
- `hsync` low width is 96 ticks, first low output on the tick after `widthPos`=656.
- `vsync` low width is 2 lines.
- Outputs change only on `tick` edges, except `frameStart` and asynchronous reset.

## Configuration
- `VGA_SYNC_BORDER_EN` defined: visible pixels with x==0, x==639, y==0 or y==479 output `rgb` = all ones, regardless of `iColor`. All other pixels behave normally. Used for monitor alignment.
- Not defined: every visible pixel outputs `iColor`. No border logic is synthesised.

## Test plan
- Reset: hold `Reset` high for 5 cycles -> `hsync`=1, `vsync`=1, `videoOn`=0, `rgb`=0, `widthPos`=0, `heightPos`=0. Release -> `widthPos` reaches 1 after exactly 2 `Clock` cycles (CLK_DIV=2).
- Horizontal timing: count ticks over one line -> `hsync` low for 96 ticks, starting 657 ticks after line start. `videoOn` high for 640 ticks per visible line.
- Vertical/frame timing: run 2 frames -> `frameStart` pulses exactly 840000 `Clock` cycles apart. `vsync` low for 1600 ticks starting at line 490. `videoOn` is never high on lines 480..524.
- Colour path and blanking: drive `iColor` = `widthPos[2:0]` -> `rgb` equals the previous tick's `widthPos[2:0]` inside the visible area, and `rgb`=0 in every blanking tick.
- Reset mid-frame: assert `Reset` at (300,200) for 1 cycle -> all outputs reach reset values within the same cycle. Counting restarts from (0,0). The next `frameStart` occurs 840000 cycles after release.
- Border (`VGA_SYNC_BORDER_EN` defined, `iColor`=3'b010): `rgb`=3'b111 at (0,y), (639,y), (x,0) and (x,479). `rgb`=3'b010 at (320,240).
